// File: rtl/rom_axi_rd_bridge.sv
// rom_axi_rd_bridge
//   AXI4 read-only slave front-end for the 2048 x 32-bit boot ROM (one-cycle
//   registered read). It accepts one read burst at a time and issues one ROM
//   word read per cycle while credit allows. Returned words are buffered in a
//   3-entry FIFO so R-channel backpressure never loses a beat.
//
//   Optional macro ROM_WR_ERR_EN adds AW/W/B ports. Any write is then
//   absorbed and answered with SLVERR; the ROM itself is never written.
//
// Ports
//   CK, RSTn                 clock (shared with ROM), async active-low reset
//   AR*                      read address channel (ARADDR[12:2] = word addr)
//   R*                       read data channel, fed from the FIFO head
//   ROM_CS/ROM_A/ROM_DO      ROM macro port; ROM_DO valid the cycle after CS
//   AW*/W*/B* (macro only)   write channels, always answered with SLVERR
module rom_axi_rd_bridge #(
   parameter int IDW = 8
) (
   input  logic           CK,
   input  logic           RSTn,
   input  logic [IDW-1:0] ARID,
   input  logic [31:0]    ARADDR,
   input  logic [7:0]     ARLEN,
   input  logic [2:0]     ARSIZE,
   input  logic [1:0]     ARBURST,
   input  logic           ARVALID,
   output logic           ARREADY,
   output logic [IDW-1:0] RID,
   output logic [31:0]    RDATA,
   output logic [1:0]     RRESP,
   output logic           RLAST,
   output logic           RVALID,
   input  logic           RREADY,
   output logic           ROM_CS,
   output logic [10:0]    ROM_A,
   input  logic [31:0]    ROM_DO
`ifdef ROM_WR_ERR_EN
   ,
   input  logic [IDW-1:0] AWID,
   input  logic           AWVALID,
   output logic           AWREADY,
   input  logic           WLAST,
   input  logic           WVALID,
   output logic           WREADY,
   output logic [IDW-1:0] BID,
   output logic [1:0]     BRESP,
   output logic           BVALID,
   input  logic           BREADY
`endif
);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_WRAP  = 2'b10;

   state_t          state, state_n;
   logic [IDW-1:0]  id_q;
   logic [10:0]     addr_q, addr_nxt, wrap_mask;
   logic [7:0]      len_q;
   logic [1:0]      burst_q;
   logic            err_q;
   logic [8:0]      cnt_q;        // reads still to issue
   logic            cap_vld_q;    // read issued last cycle, ROM_DO valid now
   logic            cap_last_q;
   logic            ar_hs, ar_err, issue, last_issue, pop, push, credit_ok;
   beat_t           fifo_q [3];
   beat_t           head;
   logic [1:0]      rd_ptr, wr_ptr, occ;

   logic unused_addr;
   assign unused_addr = ^{ARADDR[31:13], ARADDR[1:0]};

   assign ar_hs  = ARVALID && ARREADY;
   assign ar_err = (ARSIZE != 3'b010) || (ARBURST == 2'b11) ||
                   ((ARBURST == B_WRAP) && !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

   assign pop  = RVALID && RREADY;
   assign push = cap_vld_q;

   // Count every beat already committed (buffered or in flight) minus the one
   // leaving this cycle, so the FIFO can never overflow under backpressure.
   assign credit_ok  = ({1'b0, occ} + {2'b0, cap_vld_q} - {2'b0, pop}) < 3'd3;
   assign issue      = (state == BURST) && credit_ok;
   assign last_issue = (cnt_q == 9'd1);

   // Error bursts run the same issue pipeline with the ROM kept deselected,
   // which gives them the same latency and beat count as real reads.
   assign ROM_CS = issue && !err_q;
   assign ROM_A  = addr_q;

   assign wrap_mask = {3'b000, len_q};
   always_comb begin
      addr_nxt = addr_q + 11'd1;
      if (burst_q == B_FIXED)
         addr_nxt = addr_q;
      else if (burst_q == B_WRAP)
         addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + 11'd1) & wrap_mask);
   end

   // FSM
   always_ff @(posedge CK or negedge RSTn)
      if (!RSTn) state <= IDLE;
      else       state <= state_n;

   always_comb begin
      state_n = state;
      ARREADY = 1'b0;
      case (state)
         IDLE: begin
            ARREADY = RSTn;
            if (ARVALID && RSTn) state_n = BURST;
         end
         BURST:   if (issue && last_issue) state_n = DRAIN;
         DRAIN:   if (pop && RLAST)        state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Burst context and issue pipeline
   always_ff @(posedge CK or negedge RSTn)
      if (!RSTn) begin
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         burst_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         cap_vld_q  <= 1'b0;
         cap_last_q <= 1'b0;
      end else begin
         cap_vld_q  <= issue;
         cap_last_q <= issue && last_issue;
         if (ar_hs) begin
            id_q    <= ARID;
            addr_q  <= ARADDR[12:2];
            len_q   <= ARLEN;
            burst_q <= ARBURST;
            err_q   <= ar_err;
            cnt_q   <= {1'b0, ARLEN} + 9'd1;
         end else if (issue) begin
            cnt_q  <= cnt_q - 9'd1;
            addr_q <= addr_nxt;
         end
      end

   // 3-entry FIFO; ROM_DO is only looked at in the capture cycle
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge CK or negedge RSTn)
      if (!RSTn) begin
         for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr] <= '{data: err_q ? 32'd0 : ROM_DO,
                               resp: err_q ? 2'b10 : 2'b00,
                               last: cap_last_q};
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end

   assign head   = fifo_q[rd_ptr];
   assign RVALID = (occ != 2'd0);
   assign RDATA  = head.data;
   assign RRESP  = head.resp;
   assign RLAST  = head.last;
   assign RID    = id_q;

`ifdef ROM_WR_ERR_EN
   // Write sink: take AW, swallow W up to WLAST, answer SLVERR.
   logic           w_act_q, b_vld_q;
   logic [IDW-1:0] bid_q;

   assign AWREADY = !w_act_q && !b_vld_q;
   assign WREADY  = w_act_q;
   assign BVALID  = b_vld_q;
   assign BID     = bid_q;
   assign BRESP   = 2'b10;

   always_ff @(posedge CK or negedge RSTn)
      if (!RSTn) begin
         w_act_q <= 1'b0;
         b_vld_q <= 1'b0;
         bid_q   <= '0;
      end else begin
         if (AWVALID && AWREADY) begin
            w_act_q <= 1'b1;
            bid_q   <= AWID;
         end
         if (WVALID && WREADY && WLAST) begin
            w_act_q <= 1'b0;
            b_vld_q <= 1'b1;
         end
         if (BVALID && BREADY) b_vld_q <= 1'b0;
      end
`endif

endmodule

// File: tb/tb_rom_axi_rd_bridge.sv
// Testbench for rom_axi_rd_bridge: directed bursts with a scoreboard.
// Stimulus pushes expected R beats and ROM addresses into queues; a negedge
// monitor pops and compares whenever the DUT presents ROM_CS or an R beat.
module tb_rom_axi_rd_bridge;
   localparam int IDW = 8;

   logic           CK, RSTn;
   logic [IDW-1:0] ARID;
   logic [31:0]    ARADDR;
   logic [7:0]     ARLEN;
   logic [2:0]     ARSIZE;
   logic [1:0]     ARBURST;
   logic           ARVALID, ARREADY;
   logic [IDW-1:0] RID;
   logic [31:0]    RDATA;
   logic [1:0]     RRESP;
   logic           RLAST, RVALID, RREADY;
   logic           ROM_CS;
   logic [10:0]    ROM_A;
   logic [31:0]    ROM_DO;
   logic [IDW-1:0] AWID, BID;
   logic           AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic [1:0]     BRESP;

   rom_axi_rd_bridge #(.IDW(IDW)) dut (
      .CK(CK), .RSTn(RSTn),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY),
      .ROM_CS(ROM_CS), .ROM_A(ROM_A), .ROM_DO(ROM_DO)
`ifdef ROM_WR_ERR_EN
      ,
      .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`endif
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // ROM contents: ROM[4] = DEADBEEF, everything else an address-derived tag
   function automatic logic [31:0] rom_val(input logic [10:0] a);
      if (a == 11'd4) return 32'hDEADBEEF;
      return {5'h15, a, 5'h0A, ~a};
   endfunction

   // ROM model: registered read; garbage when not selected
   always @(posedge CK) ROM_DO <= ROM_CS ? rom_val(ROM_A) : 32'hBAD0BAD0;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    data;
      logic [1:0]     resp;
      logic           last;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] addr_q[$];
   exp_t        mon_e;
   int          checks = 0, errors = 0;
   int          cyc = 0, hs_cyc = 0, cs_lat = 0, rv_lat = 0, rv_first = 0, rlast_cyc = 0;
   int          cs_cnt = 0, pop_cnt = 0, beats = 0;
   bit          busy = 0, seen_cs = 0, seen_rv = 0, stall_v = 0;
   logic [42:0] stall_p;

   always @(posedge CK) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge CK) begin
      if (!RSTn) begin
         busy = 0; stall_v = 0; cs_cnt = 0; pop_cnt = 0;
      end else begin
         chk("arready", ARREADY, !busy);
         if (ARVALID && ARREADY) begin
            busy = 1; hs_cyc = cyc + 1; seen_cs = 0; seen_rv = 0;
            cs_cnt = 0; pop_cnt = 0;
         end
         if (ROM_CS) begin
            cs_cnt++;
            if (!seen_cs) begin seen_cs = 1; cs_lat = cyc - hs_cyc + 1; end
            if (addr_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rom_cs_unexpected: ROM_CS=1 at ROM_A=%0d, expected no read", ROM_A);
            end else chk("rom_a", ROM_A, addr_q.pop_front());
         end
         if (RVALID && !seen_rv) begin seen_rv = 1; rv_lat = cyc - hs_cyc + 1; rv_first = cyc; end
         if (stall_v) chk("stall_stable", {RVALID, RID, RRESP, RLAST, RDATA}, {1'b1, stall_p});
         if (RVALID && RREADY) begin
            pop_cnt++; beats++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_beat_unexpected: got data 0x%0h, expected no beat", RDATA);
            end else begin
               mon_e = exp_q.pop_front();
               chk("r_beat", {RID, RRESP, RLAST, RDATA}, {mon_e.id, mon_e.resp, mon_e.last, mon_e.data});
            end
            if (RLAST) begin busy = 0; rlast_cyc = cyc; end
         end
         chk("outstanding_le3", (cs_cnt - pop_cnt) > 3, 0);
         stall_v = RVALID && !RREADY;
         stall_p = {RID, RRESP, RLAST, RDATA};
      end
   end

   task automatic push_beat(input logic [IDW-1:0] id, input logic [31:0] d,
                            input logic [1:0] r, input logic l);
      exp_t e;
      e.id = id; e.data = d; e.resp = r; e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic push_rd(input logic [IDW-1:0] id, input logic [10:0] a, input logic l);
      addr_q.push_back(a);
      push_beat(id, rom_val(a), 2'b00, l);
   endtask

   task automatic push_incr(input logic [IDW-1:0] id, input int word, input int n);
      for (int i = 0; i < n; i++) push_rd(id, 11'((word + i) % 2048), i == n - 1);
   endtask

   task automatic do_ar(input logic [IDW-1:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit ok = 0;
      @(posedge CK); #1;
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CK);
         ok = ARREADY;
      end
      if (!ok) begin checks++; errors++; $display("FAIL ar_timeout: ARREADY=0, expected 1"); end
      @(posedge CK); #1 ARVALID = 0;
   endtask

   // Run until the scoreboard drains; mode 1 toggles RREADY 1,0,0,1,0,...
   task automatic wait_done(input bit mode);
      logic [4:0] pat = 5'b01001;
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(posedge CK); #1;
         RREADY = mode ? pat[i % 5] : 1'b1;
         @(negedge CK);
         done = (exp_q.size() == 0) && (addr_q.size() == 0) && !busy;
      end
      RREADY = 1;
      if (!done) begin
         checks++; errors++;
         $display("FAIL burst_timeout: %0d beats left, expected 0", exp_q.size());
      end
   endtask

   initial begin
      int b0;
      bit ok;
      RSTn = 0; ARVALID = 0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
      RREADY = 1; AWID = '0; AWVALID = 0; WLAST = 0; WVALID = 0; BREADY = 0;
      repeat (3) @(negedge CK);
      chk("rst_arready", ARREADY, 0);
      chk("rst_r_outputs", {RVALID, RLAST, RRESP, RID, RDATA}, 0);
      chk("rst_rom_outputs", {ROM_CS, ROM_A}, 0);
`ifdef ROM_WR_ERR_EN
      chk("rst_wr_outputs", {AWREADY, WREADY, BVALID}, 3'b100);
`endif
      @(posedge CK); #1 RSTn = 1;
      @(negedge CK);
      chk("arready_after_rst", ARREADY, 1);

      // INCR single beat at word 4
      push_rd(8'h01, 11'd4, 1);
      do_ar(8'h01, 32'h0000_0010, 8'd0, 3'b010, 2'b01);
      wait_done(0);
      chk("t1_cs_cycle", cs_lat, 1);
      chk("t1_rvalid_cycle", rv_lat, 3);
      chk("t1_cs_count", cs_cnt, 1);

      // INCR 16 across the top of the ROM
      push_incr(8'h02, 2046, 16);
      do_ar(8'h02, 32'h0000_1FF8, 8'd15, 3'b010, 2'b01);
      wait_done(0);
      chk("t2_no_bubbles", rlast_cyc - rv_first + 1, 16);

      // WRAP 4 at word 66
      push_rd(8'h03, 11'd66, 0); push_rd(8'h03, 11'd67, 0);
      push_rd(8'h03, 11'd64, 0); push_rd(8'h03, 11'd65, 1);
      do_ar(8'h03, 32'h0000_0108, 8'd3, 3'b010, 2'b10);
      wait_done(0);

      // INCR 8 with RREADY backpressure
      push_incr(8'h04, 128, 8);
      do_ar(8'h04, 32'h0000_0200, 8'd7, 3'b010, 2'b01);
      wait_done(1);

      // Bad size -> two SLVERR zero beats, no ROM reads
      push_beat(8'h05, 32'd0, 2'b10, 0);
      push_beat(8'h05, 32'd0, 2'b10, 1);
      do_ar(8'h05, 32'h0000_0020, 8'd1, 3'b001, 2'b01);
      wait_done(0);
      chk("t5_rvalid_cycle", rv_lat, 3);

      // FIXED 3 beats at word 8
      push_rd(8'h06, 11'd8, 0); push_rd(8'h06, 11'd8, 0); push_rd(8'h06, 11'd8, 1);
      do_ar(8'h06, 32'h0000_0020, 8'd2, 3'b010, 2'b00);
      wait_done(0);

      // WRAP with illegal length 3 beats -> error
      for (int i = 0; i < 3; i++) push_beat(8'h07, 32'd0, 2'b10, i == 2);
      do_ar(8'h07, 32'h0000_0040, 8'd2, 3'b010, 2'b10);
      wait_done(0);

      // Reset after beat 2 of 8, then a clean burst
      push_incr(8'h08, 256, 8);
      b0 = beats;
      do_ar(8'h08, 32'h0000_0400, 8'd7, 3'b010, 2'b01);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CK);
         ok = (beats >= b0 + 2);
      end
      if (!ok) begin checks++; errors++; $display("FAIL t8_beats: got %0d, expected 2", beats - b0); end
      @(posedge CK); #1 RSTn = 0;
      exp_q.delete(); addr_q.delete();
      @(negedge CK);
      chk("t8_rst_outputs", {RVALID, ROM_CS, ARREADY, RLAST, RDATA}, 0);
      repeat (2) @(posedge CK);
      #1 RSTn = 1;
      push_incr(8'h09, 16, 2);
      do_ar(8'h09, 32'h0000_0040, 8'd1, 3'b010, 2'b01);
      wait_done(0);

`ifdef ROM_WR_ERR_EN
      @(posedge CK); #1 AWID = 8'd5; AWVALID = 1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge CK); ok = AWREADY; end
      chk("aw_ready", ok, 1);
      @(posedge CK); #1 AWVALID = 0;
      for (int b = 0; b < 4; b++) begin
         WVALID = 1; WLAST = (b == 3);
         ok = 0;
         for (int i = 0; i < 20 && !ok; i++) begin @(negedge CK); ok = WREADY; end
         chk("w_ready", ok, 1);
         @(posedge CK); #1;
      end
      WVALID = 0; WLAST = 0;
      @(negedge CK);
      chk("b_resp", {BVALID, BID, BRESP}, {1'b1, 8'd5, 2'b10});
      @(posedge CK); #1;
      @(negedge CK);
      chk("b_held", BVALID, 1);
      @(posedge CK); #1 BREADY = 1;
      @(posedge CK); #1 BREADY = 0;
      @(negedge CK);
      chk("b_done", {BVALID, AWREADY}, 2'b01);
`endif

      repeat (3) @(posedge CK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/rom_axi_rd_bridge.md
# rom_axi_rd_bridge

AXI4 slave front-end for the 8 KiB boot ROM (`rom32x2048`, 2048 x 32-bit, one-cycle registered read). Accepts AXI4 read bursts from the system interconnect and sequences word reads into the ROM. Buffers the registered ROM data in a 3-entry FIFO so R-channel backpressure never loses a beat. Sits between the interconnect's ROM slave port and the ROM macro.

## Interface
Parameters:
- `IDW`, 8: AXI ID width.

Ports:
- `CK`, in, 1: clock, shared with the ROM.
- `RSTn`, in, 1: asynchronous, active-low reset.
- `ARID`, in, IDW: read burst ID.
- `ARADDR`, in, 32: byte address. Only [12:2] is used.
- `ARLEN`, in, 8: beats minus one.
- `ARSIZE`, in, 3: beat size.
- `ARBURST`, in, 2: burst type.
- `ARVALID`, in, 1 / `ARREADY`, out, 1: AR handshake.
- `RID`, out, IDW / `RDATA`, out, 32 / `RRESP`, out, 2 / `RLAST`, out, 1: R payload.
- `RVALID`, out, 1 / `RREADY`, in, 1: R handshake.
- `ROM_CS`, out, 1: ROM chip select; one read per asserted cycle.
- `ROM_A`, out, 11: ROM word address.
- `ROM_DO`, in, 32: ROM data, valid the cycle after `ROM_CS`.
- Present only with `ROM_WR_ERR_EN`:
  - `AWID`, `AWVALID`/`AWREADY`: write address channel.
  - `WLAST`, `WVALID`/`WREADY`: write data channel.
  - `BID`, `BRESP`, `BVALID`/`BREADY`: write response channel.

## Operation
- FSM states: IDLE, BURST, DRAIN.
- **IDLE**
  - `ARREADY`=1.
  - On handshake, latch ID, word address `ARADDR[12:2]`, beat count, burst type and error flag, then go to BURST.
- **Error flag**
  - Set when `ARSIZE`≠3'b010, or `ARBURST`=2'b11, or WRAP with `ARLEN` not in {1,3,7,15}.
- **BURST**
  - Issues one ROM read per cycle, subject to credit: `ROM_CS`=1 only if (FIFO occupancy + reads in flight − pop this cycle) < 3.
  - The next address updates per issued read:
    - INCR: +1, wrapping modulo 2048.
    - FIXED: unchanged.
    - WRAP: increments within the aligned window of (`ARLEN`+1) words.
  - After the last read issues, go to DRAIN.
- **Error bursts**
  - `ROM_CS` stays 0.
  - Exactly `ARLEN`+1 beats are still pushed to the FIFO, with `RDATA`=0 and `RRESP`=2'b10.
- **Capture**
  - A read issued in cycle k is captured from `ROM_DO` into the FIFO at the end of cycle k+1.
  - `ROM_DO` is never sampled in any other cycle, because it is X when CS is low.
- **FIFO output**
  - Head drives `RVALID`, `RDATA`, `RRESP` (2'b00 normally), `RID` and `RLAST`.
  - `RLAST`=1 on the final beat.
- **DRAIN**
  - Return to IDLE in the cycle the `RLAST` beat handshakes.
  - Exactly one burst is outstanding at a time.
- **R-channel rules**
  - Payload is stable while `RVALID`=1 and `RREADY`=0.
  - No beat is dropped or duplicated.

## Timing
- **Reset values**
  - `ARREADY`=0 during reset, 1 in the first cycle after deassert.
  - `RVALID`=0, `RLAST`=0, `RDATA`=0, `RRESP`=0, `RID`=0.
  - `ROM_CS`=0, `ROM_A`=0.
  - FIFO empty, FSM in IDLE.
  - `AWREADY`=1 and `WREADY`=0, `BVALID`=0 when the macro is compiled in.
- **Read latency**
  - AR handshake at edge T0: `ROM_CS` in cycle 1, `ROM_DO` valid in cycle 2, `RVALID` in cycle 3.
  - First-beat latency is 3 cycles.
- **Throughput**
  - One beat per cycle with `RREADY` held high, with no bubbles.
  - Next `ARREADY` is in the cycle after the `RLAST` handshake.
- **Backpressure**
  - `RREADY` low for N cycles leaves up to 3 beats buffered.
  - `ROM_CS` deasserts until credit returns.
- **Reset mid-burst**
  - `RSTn` low aborts immediately: FIFO cleared, in-flight reads discarded, outputs at reset values.
- **Error bursts**
  - Same 3-cycle first-beat latency, with beats fed from a zero source.

## Configuration
- `ROM_WR_ERR_EN` defined:
  - Adds the AW/W/B ports.
  - `AWREADY`=1 when no write is pending.
  - After an AW handshake, `WREADY`=1 and W beats are discarded until a `WLAST` handshake.
  - `BVALID` asserts the next cycle, with `BRESP`=2'b10 and `BID`=`AWID`, held until `BREADY`.
  - The ROM is never written.
  - Runs independently of the read path.
- Undefined:
  - Write ports absent; the block is read-only.
  - Writes must be decoded away by the interconnect.

## Test plan
- INCR single beat: `ARADDR`=0x0000_0010, `ARLEN`=0, ROM[4]=0xDEADBEEF -> `RVALID` in cycle 3 with `RDATA`=0xDEADBEEF, `RLAST`=1, `RRESP`=0, and `ROM_CS` for exactly 1 cycle.
- INCR 16 beats at 0x1FF8 with `RREADY`=1 -> `ROM_A` sequence 2046, 2047, 0..13, 16 consecutive beats with `RLAST` on the 16th.
- WRAP `ARLEN`=3 at 0x0000_0108 -> `ROM_A` sequence 66, 67, 64, 65.
- INCR 8 beats with `RREADY` toggled 1,0,0,1,0,... -> all 8 words delivered in order, never more than 3 buffered, payload stable while stalled.
- `ARSIZE`=3'b001, `ARLEN`=1 -> two beats with `RRESP`=2'b10, `RDATA`=0, `RLAST` on the second, `ROM_CS` never asserted.
- Reset mid-burst after beat 2 of 8 -> `RVALID`=0 immediately and a new burst returns correct data.
- With `ROM_WR_ERR_EN`: AW `AWID`=5 then 4 W beats -> one `BVALID` with `BID`=5 and `BRESP`=2'b10.
